// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-to-ALU glue: FSM state encoding and ALU opcodes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package uart_alu_pkg;

  typedef logic [2:0] state_t;

  // Frame sequencer states: three operand pops, one ALU settle/capture cycle,
  // one TX write cycle.
  localparam state_t ST_GET_A  = 3'd0;
  localparam state_t ST_GET_B  = 3'd1;
  localparam state_t ST_GET_OP = 3'd2;
  localparam state_t ST_EXEC   = 3'd3;
  localparam state_t ST_SEND   = 3'd4;

  // ALU opcode values understood by the downstream ALU.
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  // True in the three states that pop a byte from the RX FIFO.
  function automatic logic is_get_state(input state_t s);
    return (s == ST_GET_A) || (s == ST_GET_B) || (s == ST_GET_OP);
  endfunction

endpackage

// File: rtl/uart_alu_intf_timer.sv
// Partial-frame watchdog: counts stalled cycles and flags expiry at all-ones.
// Latency: expire is combinational from the count, one cycle after the last increment.
// Backpressure: none; clr has priority and expiry self-clears the count.
//
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   clr         : zero the counter this edge
//   en          : advance the counter this edge
//   expire      : one-cycle pulse while enabled with the counter at all-ones
module uart_alu_intf_timer #(
  parameter int TO_W = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  // Gated by en so a byte arriving on the same cycle wins over the abandon.
  assign expire = en & (&cnt_q);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || expire) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_alu_intf.sv
// Glue between RX FIFO, combinational ALU and TX FIFO: pops A, B, opcode, writes one result byte.
// Latency: 5 cycles per frame unstalled; tx_wr two cycles after the opcode pop.
// Backpressure: holds in GET_* while rx_empty, holds in SEND with tx_data stable while tx_full.
//
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   rx_empty, rx_data, rx_rd: RX FIFO flag, head word, pop strobe
//   tx_full, tx_data, tx_wr : TX FIFO flag, write word, write strobe
//   alu_a, alu_b, alu_op    : registered ALU operands / opcode (opcode = rx_data[OP_W-1:0])
//   alu_res                 : ALU combinational result
//   timeout                 : abandon pulse for a stalled partial frame
// Optional feature macro: UART_ALU_INTF_TIMEOUT_EN (partial-frame timeout; timeout tied 0 when undefined).
module uart_alu_intf
  import uart_alu_pkg::*;
#(
  parameter int B    = 8,
  parameter int OP_W = 6,
  parameter int TO_W = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_empty,
  input  logic [B-1:0]    rx_data,
  output logic            rx_rd,
  input  logic            tx_full,
  output logic [B-1:0]    tx_data,
  output logic            tx_wr,
  output logic [B-1:0]    alu_a,
  output logic [B-1:0]    alu_b,
  output logic [OP_W-1:0] alu_op,
  input  logic [B-1:0]    alu_res,
  output logic            timeout
);

  state_t          state_q, state_d;
  logic [B-1:0]    alu_a_q, alu_a_d;
  logic [B-1:0]    alu_b_q, alu_b_d;
  logic [OP_W-1:0] alu_op_q, alu_op_d;
  logic [B-1:0]    tx_data_q, tx_data_d;
  logic            expire;

  // Bits of the RX word above the opcode field carry no meaning here.
  logic unused_rx_hi;
  assign unused_rx_hi = ^rx_data[B-1:OP_W];

  assign rx_rd = is_get_state(state_q) & ~rx_empty;
  assign tx_wr = (state_q == ST_SEND) & ~tx_full;

`ifdef UART_ALU_INTF_TIMEOUT_EN
  logic wait_mid;
  // Only a frame that already has its A byte can be abandoned.
  assign wait_mid = (state_q == ST_GET_B) || (state_q == ST_GET_OP);

  uart_alu_intf_timer #(
    .TO_W (TO_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (rx_rd | ~wait_mid),
    .en     (wait_mid & rx_empty),
    .expire (expire)
  );
  assign timeout = expire;
`else
  logic [TO_W-1:0] unused_to_w;
  assign unused_to_w = '0;
  assign expire      = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    tx_data_d = tx_data_q;
    case (state_q)
      ST_GET_A: begin
        if (rx_rd) begin
          alu_a_d = rx_data;
          state_d = ST_GET_B;
        end
      end
      ST_GET_B: begin
        if (rx_rd) begin
          alu_b_d = rx_data;
          state_d = ST_GET_OP;
        end else if (expire) begin
          state_d = ST_GET_A;
        end
      end
      ST_GET_OP: begin
        if (rx_rd) begin
          alu_op_d = rx_data[OP_W-1:0];
          state_d  = ST_EXEC;
        end else if (expire) begin
          state_d = ST_GET_A;
        end
      end
      ST_EXEC: begin
        // Operands have been stable for a full cycle; sample the ALU.
        tx_data_d = alu_res;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (tx_wr) begin
          state_d = ST_GET_A;
        end
      end
      default: state_d = ST_GET_A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_GET_A;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_op  = alu_op_q;
  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_alu_intf.sv
// Bench for uart_alu_intf: RX FIFO and ALU models, frame-level reference model, directed frames.
// Latency: n/a.
// Backpressure: drives rx_empty gaps and tx_full stalls.
module tb_uart_alu_intf;

  localparam int B      = 8;
  localparam int OP_W   = 6;
  localparam int TO_W   = 4;
  localparam int TO_MAX = (1 << TO_W) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            rx_empty;
  logic [B-1:0]    rx_data;
  logic            rx_rd;
  logic            tx_full;
  logic [B-1:0]    tx_data;
  logic            tx_wr;
  logic [B-1:0]    alu_a;
  logic [B-1:0]    alu_b;
  logic [OP_W-1:0] alu_op;
  logic [B-1:0]    alu_res;
  logic            timeout;

  always #5 clk = ~clk;

  uart_alu_intf #(.B(B), .OP_W(OP_W), .TO_W(TO_W)) dut (
    .clk(clk), .reset(reset),
    .rx_empty(rx_empty), .rx_data(rx_data), .rx_rd(rx_rd),
    .tx_full(tx_full), .tx_data(tx_data), .tx_wr(tx_wr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
    .timeout(timeout)
  );

  // ---------------- RX FIFO model ----------------
  logic [7:0] rx_mem [0:63];
  int         rd_ptr = 0;
  int         wr_ptr = 0;
  logic       pop_now = 1'b0;

  assign rx_empty = (rd_ptr == wr_ptr);
  assign rx_data  = rx_mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    #1;
    if (pop_now) rd_ptr++;
  end

  // ---------------- ALU model ----------------
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100110: return a ^ b;
      6'b100111: return ~(a | b);
      6'b000011: return $unsigned($signed(a) >>> b);
      6'b000010: return a >> b;
      default:   return 8'h00;
    endcase
  endfunction

  always_comb alu_res = alu_fn(alu_a, alu_b, alu_op);

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame-level reference: bytes collected so far, cycles since the opcode pop,
  // cycles stalled mid-frame, and the last captured operand bytes.
  int         got = 0;
  int         post = 0;
  int         idle = 0;
  logic [7:0] sh_a = 8'h00;
  logic [7:0] sh_b = 8'h00;
  logic [5:0] sh_op = 6'h00;
  logic [7:0] exp_res = 8'h00;
  int         rd_cnt = 0;
  int         nres = 0;
  int         nto = 0;
  int         to_cyc = 0;
  logic [7:0] res_dat [0:31];
  int         res_cyc [0:31];

  always @(negedge clk) begin : cmp
    logic exp_rd, exp_wr, exp_to;
    if (reset) begin
      got = 0; post = 0; idle = 0;
      sh_a = 8'h00; sh_b = 8'h00; sh_op = 6'h00;
      pop_now = 1'b0;
    end else begin
      exp_rd = (got < 3) && !rx_empty;
      exp_wr = (got == 3) && (post >= 2) && !tx_full;
      exp_to = 1'b0;
`ifdef UART_ALU_INTF_TIMEOUT_EN
      exp_to = (got == 1 || got == 2) && rx_empty && (idle == TO_MAX);
`endif
      chk("rx_rd", rx_rd, exp_rd);
      chk("tx_wr", tx_wr, exp_wr);
      chk("timeout", timeout, exp_to);
      chk("alu_a", alu_a, sh_a);
      chk("alu_b", alu_b, sh_b);
      chk("alu_op", alu_op, sh_op);
      if (got == 3 && post >= 2) chk("tx_data", tx_data, exp_res);
      if (tx_wr && nres < 32) begin
        res_dat[nres] = tx_data;
        res_cyc[nres] = cyc;
        nres++;
      end
      if (timeout) begin
        nto++;
        to_cyc = cyc;
      end
      pop_now = rx_rd;
      if (rx_rd) rd_cnt++;
      if (exp_to) begin
        got = 0; idle = 0;
      end else if (exp_rd) begin
        idle = 0;
        case (got)
          0: sh_a = rx_data;
          1: sh_b = rx_data;
          default: begin
            sh_op   = rx_data[5:0];
            exp_res = alu_fn(sh_a, sh_b, sh_op);
            post    = 1;
          end
        endcase
        got++;
      end else if (got == 3) begin
        if (exp_wr) got = 0;
        else post++;
      end else if (got == 1 || got == 2) begin
        idle++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    rx_mem[wr_ptr[5:0]] = d;
    wr_ptr++;
  endtask

  task automatic wait_res(input int n, input string nm);
    int k = 0;
    while (nres < n && k < 200) begin
      tick(1);
      k++;
    end
    chk(nm, nres, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0, rel, ts;
    reset = 1'b1;
    tx_full = 1'b0;
    tick(3);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_rx_rd", rx_rd, 0);
    reset = 1'b0;
    tick(1);

    // ADD 5 + 3
    n0 = rd_cnt;
    push(8'h05); push(8'h03); push(8'h20);
    wait_res(1, "add_done");
    tick(2);
    chk("add_res", res_dat[0], 8'h08);
    chk("add_pops", rd_cnt - n0, 3);

    // SUB with wrap: 2 - 5
    push(8'h02); push(8'h05); push(8'h22);
    wait_res(2, "sub_done");
    chk("sub_res", res_dat[1], 8'hFD);

    // Spaced RX bytes and a long TX stall
    tx_full = 1'b1;
    push(8'h05); tick(4);
    push(8'h03); tick(4);
    push(8'h20); tick(12);
    chk("stall_held", nres, 2);
    rel = cyc;
    tx_full = 1'b0;
    wait_res(3, "stall_done");
    tick(3);
    chk("stall_res", res_dat[2], 8'h08);
    chk("stall_wr_cyc", res_cyc[2], rel);
    chk("stall_once", nres, 3);

    // Back-to-back frames: AND, OR, SRA
    push(8'h0A); push(8'h0B); push(8'h24);
    push(8'hF0); push(8'h0F); push(8'h25);
    push(8'h80); push(8'h02); push(8'h03);
    wait_res(6, "b2b_done");
    chk("b2b_and", res_dat[3], 8'h0A);
    chk("b2b_or", res_dat[4], 8'hFF);
    chk("b2b_sra", res_dat[5], 8'hE0);
    chk("b2b_gap1", res_cyc[4] - res_cyc[3], 5);
    chk("b2b_gap2", res_cyc[5] - res_cyc[4], 5);

    // Reset after two pops discards the partial frame
    n0 = rd_cnt;
    push(8'h11); push(8'h22);
    tick(2);
    chk("mid_pops", rd_cnt - n0, 2);
    chk("mid_alu_a", alu_a, 8'h11);
    reset = 1'b1;
    #1;
    chk("mid_rst_a", alu_a, 0);
    chk("mid_rst_b", alu_b, 0);
    tick(1);
    reset = 1'b0;
    tick(1);
    push(8'h07); push(8'h02); push(8'h22);
    wait_res(7, "fresh_done");
    chk("fresh_res", res_dat[6], 8'h05);

    // Lone A byte followed by a long idle
    ts = cyc;
    push(8'h05);
    tick(25);
`ifdef UART_ALU_INTF_TIMEOUT_EN
    chk("to_count", nto, 1);
    chk("to_delay", to_cyc - ts, 16);
    chk("to_keep_a", alu_a, 8'h05);
    push(8'h05); push(8'h03); push(8'h20);
`else
    chk("no_timeout", nto, 0);
    chk("idle_no_wr", nres, 7);
    push(8'h03); push(8'h20);
`endif
    wait_res(8, "last_done");
    chk("last_res", res_dat[7], 8'h08);
    tick(3);
    chk("all_popped", rd_ptr, wr_ptr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
